imm_extend_pipe: RTL and testbench
==================================

# imm_extend_pipe

Registered immediate extractor and extender for the RISC-V datapath. It generalises the 5-bit shift-amount extender into one parametrised block. The block decodes every base-ISA immediate format (I/S/B/U/J), the shift amount, and raw sign/zero extension from a 32-bit instruction word into an XLEN-wide operand. It sits between decode and execute, uses a valid/ready handshake, and holds a two-entry skid buffer, so it can be dropped into the pipelined core without stalling at full throughput.

## Interface
- XLEN, 32, output operand width; legal values 32 or 64.
- RAW_W, 12, source width for modes RAW_S/RAW_Z (1..32, taken from instr[RAW_W-1:0]).

- clk  in  1  single clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  instr/mode valid this cycle.
- in_ready  out  1  block can accept this cycle.
- instr  in  32  instruction word.
- mode  in  3  0=I, 1=S, 2=B, 3=U, 4=J, 5=SHAMT, 6=RAW_S, 7=RAW_Z.
- out_valid  out  1  imm valid.
- out_ready  in  1  downstream accepts this cycle.
- imm  out  XLEN  extended immediate.
- imm_neg  out  1  imm[XLEN-1], registered with imm.

## Operation
- Decode, combinational on input side, then extend to XLEN:
  - I: sign-extend instr[31:20].
  - S: sign-extend {instr[31:25], instr[11:7]}.
  - B: sign-extend {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}.
  - U: sign-extend {instr[31:12], 12'b0}. For XLEN=64, bits 63:32 replicate instr[31].
  - J: sign-extend {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}.
  - SHAMT: zero-extend. Uses instr[24:20] for XLEN=32 and instr[25:20] for XLEN=64. It is never sign-extended.
  - RAW_S: every bit above RAW_W-1 equals instr[RAW_W-1]. This is true replication, not a constant pattern.
  - RAW_Z: zero-extend instr[RAW_W-1:0].
- Storage consists of an output register (OR, drives imm/out_valid) and a skid register (SR).
- Accept: the transfer happens when in_valid && in_ready. in_ready = !sr_valid and is driven directly from a flop.
- On accept, data goes to OR if OR is empty or OR is draining this cycle (out_valid && out_ready). Otherwise it goes to SR.
- Drain: the transfer happens when out_valid && out_ready.
  - If SR holds data, SR moves to OR and SR becomes empty.
  - Otherwise, if there is no accept in the same cycle, OR becomes empty.
- Simultaneous accept and drain with SR empty: the new data replaces OR and out_valid stays 1.
- An accept while SR is full is impossible because in_ready=0. Input is ignored in that cycle.
- Order is strictly FIFO and data is never dropped or duplicated.
- imm/imm_neg hold their value while out_valid && !out_ready.

## Timing
- Reset (asynchronous assert, synchronous release): out_valid=0, sr_valid=0, in_ready=1, imm=0, imm_neg=0.
- Latency: data accepted at edge k is on imm with out_valid=1 from edge k (visible in cycle k+1) when OR was free.
- Throughput: 1 item per cycle while out_ready=1.
- Backpressure: the first stalled accept fills SR, and in_ready drops on the following cycle. in_ready rises the cycle after SR drains.
- Reset mid-operation: both entries are discarded immediately and outputs return to their reset values asynchronously.
- No combinational path from out_ready to in_ready.

## Test plan
- XLEN=32, mode=I, instr=0xFFF00093 -> one cycle later out_valid=1, imm=0xFFFFFFFF, imm_neg=1. Mode=I, instr=0x7FF00093 -> imm=0x000007FF.
- Modes S/B/J/SHAMT:
  - S with instr[31:25]=0x7F, instr[11:7]=0x1C -> imm=0xFFFFFFFC.
  - B with instr=0xFE000CE3 -> imm=0xFFFFFFF8.
  - J with instr=0x800000EF -> imm=0xFFF00000.
  - SHAMT with instr[24:20]=0x10 -> imm=0x00000010.
- XLEN=64, mode=U, instr=0x800000B7 -> imm=0xFFFFFFFF80000000. RAW_W=12, RAW_S, instr[11:0]=0x800 -> imm=0xFFFFFFFFFFFFF800. RAW_Z with the same instr -> 0x0000000000000800.
- Backpressure:
  - Stimulus: stream values A, B, C with out_ready=0.
  - A lands in OR and B in SR, then in_ready=0 and C is held.
  - Raising out_ready yields A, B, C in order on consecutive cycles with no loss.
- Full-rate stream of 100 random instr/mode pairs with random out_ready -> output sequence matches the reference model exactly, and in_ready never depends combinationally on out_ready.
- Assert rst_n low mid-stream with OR and SR full -> out_valid=0 and in_ready=1 immediately. After release the first new accept appears 1 cycle later.

Source files
------------

// File: rtl/imm_extend_pipe_if.sv
// Handshake bundle for imm_extend_pipe: input side (instr/mode with
// valid/ready) and output side (imm/imm_neg with valid/ready).
interface imm_extend_pipe_if #(
  parameter int unsigned XLEN = 32
);
  // Upstream (decode) side
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     instr;
  logic [2:0]      mode;

  // Downstream (execute) side
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] imm;
  logic            imm_neg;

  // Driver of the bundle: decode stage upstream, execute stage downstream
  modport master (
    output in_valid,
    output instr,
    output mode,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  imm,
    input  imm_neg
  );

  // The extender itself
  modport slave (
    input  in_valid,
    input  instr,
    input  mode,
    input  out_ready,
    output in_ready,
    output out_valid,
    output imm,
    output imm_neg
  );
endinterface

// File: rtl/imm_extend_pipe.sv
// Registered RISC-V immediate extractor/extender with a two-entry skid
// buffer (output register + skid register). Decodes I/S/B/U/J immediates,
// shift amounts and raw sign/zero extension into an XLEN-wide operand.
module imm_extend_pipe #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned RAW_W = 12
) (
  input  logic                clk,
  input  logic                rst_n,
  imm_extend_pipe_if.slave    bus
);

  // Immediate format selector encoding on the mode input
  typedef enum logic [2:0] {
    M_I     = 3'd0,
    M_S     = 3'd1,
    M_B     = 3'd2,
    M_U     = 3'd3,
    M_J     = 3'd4,
    M_SHAMT = 3'd5,
    M_RAW_S = 3'd6,
    M_RAW_Z = 3'd7
  } mode_e;

  // Buffer occupancy: ST_ONE = output register only, ST_FULL = output
  // register plus skid register.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } occ_e;

  occ_e            state_q, state_d;
  logic [XLEN-1:0] or_q, or_d;
  logic [XLEN-1:0] sr_q, sr_d;
  logic            in_ready_q, in_ready_d;
  logic [XLEN-1:0] dec;
  logic            accept;
  logic            drain;
  mode_e           mode_sel;

  assign mode_sel = mode_e'(bus.mode);
  assign accept   = bus.in_valid && in_ready_q;
  assign drain    = (state_q != ST_EMPTY) && bus.out_ready;

  // Combinational decode and extension of the presented instruction
  always_comb begin
    dec = '0;
    case (mode_sel)
      M_I:     dec = XLEN'($signed(bus.instr[31:20]));
      M_S:     dec = XLEN'($signed({bus.instr[31:25], bus.instr[11:7]}));
      M_B:     dec = XLEN'($signed({bus.instr[31], bus.instr[7],
                                    bus.instr[30:25], bus.instr[11:8],
                                    1'b0}));
      M_U:     dec = XLEN'($signed({bus.instr[31:12], 12'b0}));
      M_J:     dec = XLEN'($signed({bus.instr[31], bus.instr[19:12],
                                    bus.instr[20], bus.instr[30:21],
                                    1'b0}));
      M_SHAMT: begin
        if (XLEN == 64) dec = XLEN'(bus.instr[25:20]);
        else            dec = XLEN'(bus.instr[24:20]);
      end
      M_RAW_S: dec = XLEN'($signed(bus.instr[RAW_W-1:0]));
      M_RAW_Z: dec = XLEN'(bus.instr[RAW_W-1:0]);
      default: dec = '0;
    endcase
  end

  // Next-state, data steering and registered ready
  always_comb begin
    state_d = state_q;
    or_d    = or_q;
    sr_d    = sr_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          or_d    = dec;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (accept && drain) begin
          // OR drains and refills in the same cycle; out_valid stays high
          or_d    = dec;
          state_d = ST_ONE;
        end else if (accept) begin
          sr_d    = dec;
          state_d = ST_FULL;
        end else if (drain) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        // in_ready is low here, so no accept can coincide with this drain
        if (drain) begin
          or_d    = sr_q;
          state_d = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    // Ready is precomputed from the next occupancy so the output is a
    // plain flop with no path from out_ready.
    in_ready_d = (state_d != ST_FULL);
  end

  // Occupancy and ready registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
    end
  end

  // Output and skid data registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      or_q <= '0;
      sr_q <= '0;
    end else begin
      or_q <= or_d;
      sr_q <= sr_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = (state_q != ST_EMPTY);
  assign bus.imm       = or_q;
  assign bus.imm_neg   = or_q[XLEN-1];

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Self-checking bench: XLEN=32 and XLEN=64 instances driven in lockstep,
// compared against a queue-based reference model.
module tb_imm_extend_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] instr;
  logic [2:0]  mode;
  logic        out_ready;

  int          n_assert = 0;
  int          n_fail   = 0;
  int          n_acc    = 0;
  int          cyc      = 0;
  logic        m_inready;
  logic [63:0] q32[$];
  logic [63:0] q64[$];

  always #5 clk = ~clk;

  imm_extend_pipe_if #(.XLEN(32)) b32 ();
  imm_extend_pipe_if #(.XLEN(64)) b64 ();

  assign b32.in_valid  = in_valid;
  assign b32.instr     = instr;
  assign b32.mode      = mode;
  assign b32.out_ready = out_ready;
  assign b64.in_valid  = in_valid;
  assign b64.instr     = instr;
  assign b64.mode      = mode;
  assign b64.out_ready = out_ready;

  imm_extend_pipe #(.XLEN(32), .RAW_W(12)) u32 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b32.slave)
  );

  imm_extend_pipe #(.XLEN(64), .RAW_W(12)) u64 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b64.slave)
  );

  // Sign-extend the low w bits of v to 64 bits
  function automatic logic [63:0] sx(input logic [63:0] v, input int w);
    longint s;
    s = longint'(v << (64 - w));
    return 64'(s >>> (64 - w));
  endfunction

  // Reference immediate straight from the format rules
  function automatic logic [63:0] ref_imm(input logic [31:0] ins,
                                          input logic [2:0] m,
                                          input int xlen);
    logic [63:0] r;
    case (m)
      3'd0: r = sx(64'(ins[31:20]), 12);
      3'd1: r = sx(64'({ins[31:25], ins[11:7]}), 12);
      3'd2: r = sx(64'({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}), 13);
      3'd3: r = sx(64'({ins[31:12], 12'b0}), 32);
      3'd4: r = sx(64'({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}), 21);
      3'd5: r = (xlen == 64) ? 64'(ins[25:20]) : 64'(ins[24:20]);
      3'd6: r = sx(64'(ins[11:0]), 12);
      default: r = 64'(ins[11:0]);
    endcase
    if (xlen == 32) r = {32'b0, r[31:0]};
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: present inputs, probe ready independence from
  // out_ready, advance the model across the edge, then check outputs.
  task automatic tick(input logic v, input logic [31:0] ins,
                      input logic [2:0] m, input logic ordy);
    logic acc, drn;
    logic [63:0] e32, e64;
    in_valid  = v;
    instr     = ins;
    mode      = m;
    out_ready = !ordy;
    #1;
    chk("in_ready_indep32", 64'(b32.in_ready), 64'(m_inready));
    chk("in_ready_indep64", 64'(b64.in_ready), 64'(m_inready));
    out_ready = ordy;
    #1;
    acc = v && m_inready;
    drn = ordy && (q32.size() != 0);
    @(posedge clk);
    #1;
    cyc++;
    if (drn) begin
      e32 = q32.pop_front();
      e64 = q64.pop_front();
    end
    if (acc) begin
      q32.push_back(ref_imm(ins, m, 32));
      q64.push_back(ref_imm(ins, m, 64));
      n_acc++;
    end
    m_inready = (q32.size() < 2);
    chk("in_ready32", 64'(b32.in_ready), 64'(m_inready));
    chk("out_valid32", 64'(b32.out_valid), 64'(q32.size() != 0));
    chk("out_valid64", 64'(b64.out_valid), 64'(q64.size() != 0));
    if (q32.size() != 0) begin
      e32 = q32[0];
      e64 = q64[0];
      chk("imm32", 64'(b32.imm), e32);
      chk("imm64", b64.imm, e64);
      chk("imm_neg32", 64'(b32.imm_neg), 64'(e32[31]));
      chk("imm_neg64", 64'(b64.imm_neg), 64'(e64[63]));
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ov32"}, 64'(b32.out_valid), 64'd0);
    chk({tag, "_ov64"}, 64'(b64.out_valid), 64'd0);
    chk({tag, "_ir32"}, 64'(b32.in_ready), 64'd1);
    chk({tag, "_ir64"}, 64'(b64.in_ready), 64'd1);
    chk({tag, "_imm32"}, 64'(b32.imm), 64'd0);
    chk({tag, "_imm64"}, b64.imm, 64'd0);
    chk({tag, "_neg32"}, 64'(b32.imm_neg), 64'd0);
    chk({tag, "_neg64"}, 64'(b64.imm_neg), 64'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    instr     = '0;
    mode      = '0;
    out_ready = 1'b0;
    m_inready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    rst_n = 1'b1;

    // Directed formats, one per cycle at full rate
    tick(1'b1, 32'hFFF0_0093, 3'd0, 1'b1);
    chk("I_neg32", 64'(b32.imm), 64'h0000_0000_FFFF_FFFF);
    chk("I_neg_flag32", 64'(b32.imm_neg), 64'd1);
    tick(1'b1, 32'h7FF0_0093, 3'd0, 1'b1);
    chk("I_pos32", 64'(b32.imm), 64'h0000_07FF);
    tick(1'b1, 32'hFE00_0E00, 3'd1, 1'b1);
    chk("S32", 64'(b32.imm), 64'h0000_0000_FFFF_FFFC);
    tick(1'b1, 32'hFE00_0CE3, 3'd2, 1'b1);
    chk("B32", 64'(b32.imm), 64'h0000_0000_FFFF_FFF8);
    tick(1'b1, 32'h8000_00EF, 3'd4, 1'b1);
    chk("J32", 64'(b32.imm), 64'h0000_0000_FFF0_0000);
    tick(1'b1, 32'h0100_0000, 3'd5, 1'b1);
    chk("SHAMT32", 64'(b32.imm), 64'h10);
    tick(1'b1, 32'h0200_0000, 3'd5, 1'b1);
    chk("SHAMT32_bit25", 64'(b32.imm), 64'h0);
    chk("SHAMT64_bit25", b64.imm, 64'h20);
    tick(1'b1, 32'h8000_00B7, 3'd3, 1'b1);
    chk("U64", b64.imm, 64'hFFFF_FFFF_8000_0000);
    chk("U32", 64'(b32.imm), 64'h8000_0000);
    tick(1'b1, 32'h0000_0800, 3'd6, 1'b1);
    chk("RAW_S64", b64.imm, 64'hFFFF_FFFF_FFFF_F800);
    tick(1'b1, 32'h0000_0800, 3'd7, 1'b1);
    chk("RAW_Z64", b64.imm, 64'h0000_0000_0000_0800);
    tick(1'b0, 32'h0, 3'd0, 1'b1);

    // Backpressure: A to OR, B to SR, C held until ready returns
    tick(1'b1, 32'h0010_0000, 3'd0, 1'b0);   // A = 1
    tick(1'b1, 32'h0020_0000, 3'd0, 1'b0);   // B = 2
    chk("bp_in_ready_low", 64'(b32.in_ready), 64'd0);
    chk("bp_head_A", 64'(b32.imm), 64'd1);
    tick(1'b1, 32'h0030_0000, 3'd0, 1'b0);   // C = 3, refused
    chk("bp_hold_A", 64'(b32.imm), 64'd1);
    tick(1'b1, 32'h0030_0000, 3'd0, 1'b1);
    chk("bp_out_B", 64'(b32.imm), 64'd2);
    tick(1'b1, 32'h0030_0000, 3'd0, 1'b1);
    chk("bp_out_C", 64'(b32.imm), 64'd3);
    tick(1'b0, 32'h0, 3'd0, 1'b1);
    chk("bp_empty", 64'(b32.out_valid), 64'd0);

    // Random stream of 100 accepted items with random backpressure
    n_acc = 0;
    cyc   = 0;
    while (n_acc < 100 && cyc < 3000)
      tick(($urandom % 4) != 0, $urandom, 3'($urandom % 8),
           1'($urandom % 2));
    chk("rand_accept_count", 64'(n_acc), 64'd100);
    repeat (4) tick(1'b0, 32'h0, 3'd0, 1'b1);
    chk("rand_drained", 64'(b32.out_valid), 64'd0);

    // Asynchronous reset with both entries full
    tick(1'b1, 32'hFFF0_0000, 3'd0, 1'b0);
    tick(1'b1, 32'h0050_0000, 3'd0, 1'b0);
    chk("pre_rst_full", 64'(b32.in_ready), 64'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("midrst");
    q32.delete();
    q64.delete();
    m_inready = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick(1'b1, 32'h0070_0000, 3'd0, 1'b0);
    chk("post_rst_first", 64'(b32.imm), 64'd7);
    tick(1'b0, 32'h0, 3'd0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
